// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one apb_master_if among REQ_NUM requesters.
// Define APB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module apb_master_arbiter #(
    parameter int REQ_NUM        = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
) (
    input  logic                                apb_clk_in,
    input  logic                                apb_rstn_in,
    input  logic [REQ_NUM-1:0]                  req_sel_in,
    input  logic [REQ_NUM-1:0]                  req_write_in,
    input  logic [REQ_NUM*APB_ADDR_WIDTH-1:0]   req_addr_in,
    input  logic [REQ_NUM*APB_DATA_WIDTH-1:0]   req_wdata_in,
    output logic [REQ_NUM-1:0]                  req_grant_out,
    output logic [REQ_NUM-1:0]                  req_ready_out,
    output logic [REQ_NUM-1:0]                  req_error_out,
    output logic [APB_DATA_WIDTH-1:0]           req_rdata_out,
    output logic                                m_sel_out,
    output logic                                m_write_out,
    output logic [APB_ADDR_WIDTH-1:0]           m_addr_out,
    output logic [APB_DATA_WIDTH-1:0]           m_wdata_out,
    input  logic                                m_ready_in,
    input  logic                                m_error_in,
    input  logic [APB_DATA_WIDTH-1:0]           m_rdata_in,
    output logic                                busy_out
);

    localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        BUSY    = 3'b010,
        RELEASE = 3'b100
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] win;

`ifdef APB_ARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (req_sel_in[i]) win = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0] last_grant;

    // Scan offsets from farthest to nearest so the nearest pending requester after last_grant wins.
    always_comb begin
        win = '0;
        for (int k = REQ_NUM; k >= 1; k--) begin
            int idx;
            idx = int'(last_grant) + k;
            if (idx >= REQ_NUM) idx = idx - REQ_NUM;
            if (req_sel_in[idx]) win = IDX_W'(idx);
        end
    end
`endif

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            state         <= IDLE;
            req_grant_out <= '0;
            req_ready_out <= '0;
            req_error_out <= '0;
            req_rdata_out <= '0;
            m_sel_out     <= 1'b0;
            m_write_out   <= 1'b0;
            m_addr_out    <= '0;
            m_wdata_out   <= '0;
            busy_out      <= 1'b0;
`ifndef APB_ARB_FIXED_PRIO_EN
            last_grant    <= IDX_W'(REQ_NUM - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_ready_out <= '0;
                    req_error_out <= '0;
                    if (|req_sel_in) begin
                        m_sel_out     <= 1'b1;
                        m_write_out   <= req_write_in[win];
                        m_addr_out    <= req_addr_in[int'(win)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                        m_wdata_out   <= req_write_in[win] ?
                                         req_wdata_in[int'(win)*APB_DATA_WIDTH +: APB_DATA_WIDTH] : '0;
                        req_grant_out <= REQ_NUM'(1) << win;
                        busy_out      <= 1'b1;
                        state         <= BUSY;
`ifndef APB_ARB_FIXED_PRIO_EN
                        last_grant    <= win;
`endif
                    end
                end
                BUSY: begin
                    // Payload stays frozen here; requester inputs are not looked at.
                    if (m_ready_in) begin
                        req_ready_out <= req_grant_out;
                        req_error_out <= m_error_in ? req_grant_out : '0;
                        req_rdata_out <= m_write_out ? '0 : m_rdata_in;
                        m_sel_out     <= 1'b0;
                        req_grant_out <= '0;
                        state         <= RELEASE;
                    end
                end
                RELEASE: begin
                    req_ready_out <= '0;
                    req_error_out <= '0;
                    if (!m_ready_in) begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    req_grant_out <= '0;
                    req_ready_out <= '0;
                    req_error_out <= '0;
                    m_sel_out     <= 1'b0;
                    busy_out      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
